pll_lock_ctrl: RTL and testbench
================================

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default `NUM_STAGES (15): number of coarse DCO settings.
REQ-002 SHALL have parameter LOCK_CNT, default 8: consecutive qualifying events needed to advance lock state.
REQ-003 SHALL have parameter COARSE_TOL, default 4: coarse-lock frequency error window, in counts.
REQ-004 SHALL have parameter UNLOCK_TOL, default 16: loss-of-lock error threshold, in counts.
REQ-005 SHALL have parameter BRAKE_CYCLES, default 16: code-freeze duration in refclk cycles.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 refclk  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 enable  in  1  low = controller held in reset state, synchronously.
REQ-010 fcw  in  12  target DCO edges per refclk period.
REQ-011 dco_count  in  12  measured DCO edges per refclk period.
REQ-012 count_valid  in  1  dco_count qualifier, one-cycle pulse.
REQ-013 pd_valid  in  1  phase-detector sample qualifier.
REQ-014 pd_early  in  1  1 = DCO early (slow down), 0 = late (speed up).
REQ-015 coarse_code  out  $clog2(NUM_STAGES)  coarse DCO setting, range 0..NUM_STAGES-1.
REQ-016 fine_code  out  8  fine DCO setting, range 0..255.
REQ-017 lock_state  out  lock_state_t  current acquisition phase.
REQ-018 brake_state  out  brake_state_t  loss-of-lock recovery status.
REQ-019 locked  out  1  high iff lock_state==PHASE_LOCKED.

Function
REQ-020 err SHALL be 13-bit signed fcw - dco_count; positive means DCO too slow.
REQ-021 All outputs SHALL be registered; an update caused by a valid sampled at edge N SHALL be visible after edge N.
REQ-022 UNLOCKED, count_valid: err>COARSE_TOL -> coarse+1; err<-COARSE_TOL -> coarse-1; otherwise good_cnt+1.
REQ-023 Any out-of-window sample SHALL clear good_cnt.
REQ-024 good_cnt reaching LOCK_CNT SHALL enter COARSE_FREQ_LOCKED, clear good_cnt and set fine_code=128.
REQ-025 COARSE_FREQ_LOCKED, count_valid: err>0 -> fine+1; err<0 -> fine-1; err==0 -> good_cnt+1, else good_cnt cleared.
REQ-026 In COARSE_FREQ_LOCKED, good_cnt reaching LOCK_CNT SHALL enter FINE_FREQ_LOCKED.
REQ-027 FINE_FREQ_LOCKED/PHASE_LOCKED, pd_valid: pd_early -> fine-1, else fine+1.
REQ-028 On each pd_valid, alt_cnt SHALL increment if the direction differs from the previous one, else reset to 0.
REQ-029 In FINE_FREQ_LOCKED, alt_cnt reaching LOCK_CNT SHALL enter PHASE_LOCKED.
REQ-030 PHASE_LOCKED SHALL be left only by loss of lock (REQ-032), enable low, or reset.
REQ-031 coarse_code SHALL saturate at 0 and NUM_STAGES-1, and fine_code at 0 and 255; no wrap-around.
REQ-032 Outside UNLOCKED, count_valid with |err|>UNLOCK_TOL SHALL set lock_state=UNLOCKED and brake_state=BRAKING, and clear all counters.
REQ-033 BRAKING SHALL freeze codes and ignore count_valid/pd_valid for BRAKE_CYCLES cycles, then go to RECOVERING.
REQ-034 RECOVERING SHALL run the UNLOCKED search; entry to COARSE_FREQ_LOCKED SHALL set BRAKES_OFF.
REQ-035 If count_valid and pd_valid coincide in FINE_FREQ_LOCKED/PHASE_LOCKED, the loss check wins; if no loss, the pd update applies and the count is otherwise ignored.

Reset
REQ-036 reset SHALL immediately set coarse_code=NUM_STAGES/2 (7), fine_code=128, UNLOCKED, BRAKES_OFF, locked=0 and all counters 0.
REQ-037 Reset asserted mid-operation, including during BRAKING, SHALL abort all activity without waiting for a clock edge.
REQ-038 enable low SHALL apply the REQ-036 values at the next refclk edge.

Structure
REQ-039 lock_state_t, brake_state_t, NUM_STAGES, KDCO_COARSE and KDCO_FINE SHALL live in shared package pll_pkg.
REQ-040 Error computation and window compares SHALL be sub-module pll_freq_err, which is purely combinational.

Verification
REQ-041 fcw=100, dco_count=90, one count_valid -> coarse_code 7->8 next cycle, state UNLOCKED.
REQ-042 dco_count=102 on 8 count_valids -> COARSE_FREQ_LOCKED after the 8th, fine_code=128.
REQ-043 COARSE_FREQ_LOCKED, dco_count=99 repeated 130 times -> fine_code saturates at 255, no wrap.
REQ-044 FINE_FREQ_LOCKED, pd_early alternating 1,0 for 9 pd_valids -> PHASE_LOCKED, locked=1, fine_code=128 +/- 1.
REQ-045 PHASE_LOCKED, dco_count=130 -> UNLOCKED+BRAKING, codes frozen 16 cycles, then RECOVERING, BRAKES_OFF at next coarse lock.
REQ-046 reset pulsed at cycle 5 of BRAKING -> REQ-036 values visible before the next refclk edge.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL lock controller.
package pll_pkg;

  localparam int unsigned NUM_STAGES  = 15;
  // Nominal DCO gain per code step, in kHz.
  localparam int unsigned KDCO_COARSE = 2000;
  localparam int unsigned KDCO_FINE   = 20;

  localparam logic [7:0] FINE_MID = 8'd128;
  localparam logic [7:0] FINE_MAX = 8'd255;

  typedef enum logic [1:0] {
    UNLOCKED,
    COARSE_FREQ_LOCKED,
    FINE_FREQ_LOCKED,
    PHASE_LOCKED
  } lock_state_t;

  typedef enum logic [1:0] {
    BRAKES_OFF,
    BRAKING,
    RECOVERING
  } brake_state_t;

  function automatic logic [7:0] fine_step(logic [7:0] code, logic up);
    logic [7:0] res;
    res = code;
    if (up) begin
      if (code != FINE_MAX) res = code + 8'd1;
    end else begin
      if (code != 8'd0) res = code - 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pll_freq_err.sv
// Frequency error fcw - dco_count and its window compares; purely combinational.
module pll_freq_err #(
  parameter int COARSE_TOL = 4,
  parameter int UNLOCK_TOL = 16
) (
  input  logic [11:0] fcw_i,
  input  logic [11:0] dco_count_i,
  output logic        coarse_hi_o,
  output logic        coarse_lo_o,
  output logic        err_pos_o,
  output logic        err_neg_o,
  output logic        loss_o
);

  localparam logic signed [12:0] CoarseTol = 13'(COARSE_TOL);
  localparam logic signed [12:0] UnlockTol = 13'(UNLOCK_TOL);

  logic signed [12:0] err;

  // Positive error means the DCO runs too slow.
  assign err = $signed({1'b0, fcw_i}) - $signed({1'b0, dco_count_i});

  assign coarse_hi_o = err > CoarseTol;
  assign coarse_lo_o = err < -CoarseTol;
  assign err_pos_o   = err > 13'sd0;
  assign err_neg_o   = err < 13'sd0;
  assign loss_o      = (err > UnlockTol) || (err < -UnlockTol);

endmodule

// File: rtl/pll_lock_ctrl.sv
// Digital PLL acquisition controller: coarse search, fine frequency trim,
// phase tracking and loss-of-lock braking/recovery.
module pll_lock_ctrl
  import pll_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = pll_pkg::NUM_STAGES,
  parameter int unsigned LOCK_CNT     = 8,
  parameter int unsigned COARSE_TOL   = 4,
  parameter int unsigned UNLOCK_TOL   = 16,
  parameter int unsigned BRAKE_CYCLES = 16
) (
  input  logic                          refclk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [11:0]                   fcw,
  input  logic [11:0]                   dco_count,
  input  logic                          count_valid,
  input  logic                          pd_valid,
  input  logic                          pd_early,
  output logic [$clog2(NUM_STAGES)-1:0] coarse_code,
  output logic [7:0]                    fine_code,
  output lock_state_t                   lock_state,
  output brake_state_t                  brake_state,
  output logic                          locked
);

  localparam int unsigned CW   = $clog2(NUM_STAGES);
  localparam int unsigned CntW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BrkW = $clog2(BRAKE_CYCLES + 1);

  localparam logic [CW-1:0]   CoarseMax = CW'(NUM_STAGES - 1);
  localparam logic [CW-1:0]   CoarseRst = CW'(NUM_STAGES / 2);
  localparam logic [CntW-1:0] CntLast   = CntW'(LOCK_CNT - 1);
  localparam logic [CntW-1:0] CntFull   = CntW'(LOCK_CNT);
  localparam logic [BrkW-1:0] BrkLast   = BrkW'(BRAKE_CYCLES - 1);

  logic [CW-1:0]   coarse_q, coarse_d;
  logic [7:0]      fine_q, fine_d;
  lock_state_t     lock_q, lock_d;
  brake_state_t    brake_q, brake_d;
  logic [CntW-1:0] good_q, good_d;
  logic [CntW-1:0] alt_q, alt_d;
  logic [BrkW-1:0] brk_q, brk_d;
  logic            prev_dir_q, prev_dir_d;
  logic            prev_vld_q, prev_vld_d;

  logic coarse_hi, coarse_lo, err_pos, err_neg, err_loss;

  pll_freq_err #(
    .COARSE_TOL(int'(COARSE_TOL)),
    .UNLOCK_TOL(int'(UNLOCK_TOL))
  ) u_freq_err (
    .fcw_i      (fcw),
    .dco_count_i(dco_count),
    .coarse_hi_o(coarse_hi),
    .coarse_lo_o(coarse_lo),
    .err_pos_o  (err_pos),
    .err_neg_o  (err_neg),
    .loss_o     (err_loss)
  );

  always_comb begin
    coarse_d   = coarse_q;
    fine_d     = fine_q;
    lock_d     = lock_q;
    brake_d    = brake_q;
    good_d     = good_q;
    alt_d      = alt_q;
    brk_d      = brk_q;
    prev_dir_d = prev_dir_q;
    prev_vld_d = prev_vld_q;

    if (!enable) begin
      coarse_d   = CoarseRst;
      fine_d     = FINE_MID;
      lock_d     = UNLOCKED;
      brake_d    = BRAKES_OFF;
      good_d     = '0;
      alt_d      = '0;
      brk_d      = '0;
      prev_dir_d = 1'b0;
      prev_vld_d = 1'b0;
    end else if (brake_q == BRAKING) begin
      // Codes frozen and all qualifiers ignored while the brake timer runs.
      if (brk_q == BrkLast) begin
        brake_d = RECOVERING;
        brk_d   = '0;
      end else begin
        brk_d = brk_q + 1'b1;
      end
    end else if (count_valid && err_loss && (lock_q != UNLOCKED)) begin
      lock_d     = UNLOCKED;
      brake_d    = BRAKING;
      good_d     = '0;
      alt_d      = '0;
      brk_d      = '0;
      prev_vld_d = 1'b0;
    end else begin
      unique case (lock_q)
        UNLOCKED: begin
          if (count_valid) begin
            if (coarse_hi) begin
              if (coarse_q != CoarseMax) coarse_d = coarse_q + 1'b1;
              good_d = '0;
            end else if (coarse_lo) begin
              if (coarse_q != '0) coarse_d = coarse_q - 1'b1;
              good_d = '0;
            end else if (good_q == CntLast) begin
              lock_d  = COARSE_FREQ_LOCKED;
              good_d  = '0;
              fine_d  = FINE_MID;
              brake_d = BRAKES_OFF;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
        COARSE_FREQ_LOCKED: begin
          if (count_valid) begin
            if (err_pos || err_neg) begin
              fine_d = fine_step(fine_q, err_pos);
              good_d = '0;
            end else if (good_q == CntLast) begin
              lock_d     = FINE_FREQ_LOCKED;
              good_d     = '0;
              alt_d      = '0;
              prev_vld_d = 1'b0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
        FINE_FREQ_LOCKED, PHASE_LOCKED: begin
          if (pd_valid) begin
            fine_d = fine_step(fine_q, !pd_early);
            // The first sample after entry has no previous direction to alternate from.
            if (prev_vld_q && (pd_early != prev_dir_q)) begin
              if (alt_q != CntFull) alt_d = alt_q + 1'b1;
              if ((lock_q == FINE_FREQ_LOCKED) && (alt_q == CntLast)) lock_d = PHASE_LOCKED;
            end else begin
              alt_d = '0;
            end
            prev_dir_d = pd_early;
            prev_vld_d = 1'b1;
          end
        end
        default: lock_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      coarse_q   <= CoarseRst;
      fine_q     <= FINE_MID;
      lock_q     <= UNLOCKED;
      brake_q    <= BRAKES_OFF;
      good_q     <= '0;
      alt_q      <= '0;
      brk_q      <= '0;
      prev_dir_q <= 1'b0;
      prev_vld_q <= 1'b0;
    end else begin
      coarse_q   <= coarse_d;
      fine_q     <= fine_d;
      lock_q     <= lock_d;
      brake_q    <= brake_d;
      good_q     <= good_d;
      alt_q      <= alt_d;
      brk_q      <= brk_d;
      prev_dir_q <= prev_dir_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign coarse_code = coarse_q;
  assign fine_code   = fine_q;
  assign lock_state  = lock_q;
  assign brake_state = brake_q;
  assign locked      = (lock_q == PHASE_LOCKED);

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl against a behavioural acquisition model.
module tb_pll_lock_ctrl;
  import pll_pkg::*;

  localparam int NS     = 15;
  localparam int LCNT   = 8;
  localparam int CTOL   = 4;
  localparam int UTOL   = 16;
  localparam int BRAKES = 16;

  logic        refclk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] fcw;
  logic [11:0] dco_count;
  logic        count_valid;
  logic        pd_valid;
  logic        pd_early;
  logic [3:0]  coarse_code;
  logic [7:0]  fine_code;
  lock_state_t  lock_state;
  brake_state_t brake_state;
  logic        locked;

  pll_lock_ctrl dut (
    .refclk     (refclk),
    .reset      (reset),
    .enable     (enable),
    .fcw        (fcw),
    .dco_count  (dco_count),
    .count_valid(count_valid),
    .pd_valid   (pd_valid),
    .pd_early   (pd_early),
    .coarse_code(coarse_code),
    .fine_code  (fine_code),
    .lock_state (lock_state),
    .brake_state(brake_state),
    .locked     (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int           coarse;
    int           fine;
    lock_state_t  phase;
    brake_state_t brake;
    int           lck;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_push = 0;
  int   n_pop = 0;
  int   cur_fcw = 100;

  // Behavioural model state
  int           m_coarse, m_fine, m_good, m_alt, m_brk, m_last;
  lock_state_t  m_phase;
  brake_state_t m_brake;

  task automatic chk(string name, int got, int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
  endtask

  function automatic int clamp(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic void model_reset();
    m_coarse = NS / 2;
    m_fine   = 128;
    m_phase  = UNLOCKED;
    m_brake  = BRAKES_OFF;
    m_good   = 0;
    m_alt    = 0;
    m_brk    = 0;
    m_last   = -1;
  endfunction

  function automatic void model_lose();
    m_phase = UNLOCKED;
    m_brake = BRAKING;
    m_good  = 0;
    m_alt   = 0;
    m_brk   = 0;
    m_last  = -1;
  endfunction

  function automatic void model_step(bit en, bit cv, bit pv, bit early, int e);
    int ae;
    ae = (e < 0) ? -e : e;
    if (!en) begin
      model_reset();
    end else if (m_brake == BRAKING) begin
      m_brk++;
      if (m_brk == BRAKES) begin
        m_brake = RECOVERING;
        m_brk   = 0;
      end
    end else if (m_phase == UNLOCKED) begin
      if (cv) begin
        if (e > CTOL) begin
          m_coarse = clamp(m_coarse + 1, 0, NS - 1);
          m_good   = 0;
        end else if (e < -CTOL) begin
          m_coarse = clamp(m_coarse - 1, 0, NS - 1);
          m_good   = 0;
        end else begin
          m_good++;
          if (m_good == LCNT) begin
            m_phase = COARSE_FREQ_LOCKED;
            m_good  = 0;
            m_fine  = 128;
            m_brake = BRAKES_OFF;
          end
        end
      end
    end else if (cv && ae > UTOL) begin
      model_lose();
    end else if (m_phase == COARSE_FREQ_LOCKED) begin
      if (cv) begin
        if (e != 0) begin
          m_fine = clamp(m_fine + ((e > 0) ? 1 : -1), 0, 255);
          m_good = 0;
        end else begin
          m_good++;
          if (m_good == LCNT) begin
            m_phase = FINE_FREQ_LOCKED;
            m_good  = 0;
            m_alt   = 0;
            m_last  = -1;
          end
        end
      end
    end else if (pv) begin
      m_fine = clamp(m_fine + (early ? -1 : 1), 0, 255);
      if (m_last >= 0 && m_last != int'(early)) m_alt++;
      else m_alt = 0;
      m_last = int'(early);
      if (m_phase == FINE_FREQ_LOCKED && m_alt >= LCNT) m_phase = PHASE_LOCKED;
    end
  endfunction

  // One refclk cycle of stimulus; expectation is queued once the edge has occurred.
  task automatic cyc(bit en, bit cv, bit pv, bit early, int e);
    exp_t x;
    enable      = en;
    count_valid = cv;
    pd_valid    = pv;
    pd_early    = early;
    fcw         = 12'(cur_fcw);
    dco_count   = 12'(cur_fcw - e);
    model_step(en, cv, pv, early, e);
    x.coarse = m_coarse;
    x.fine   = m_fine;
    x.phase  = m_phase;
    x.brake  = m_brake;
    x.lck    = (m_phase == PHASE_LOCKED) ? 1 : 0;
    @(posedge refclk);
    sb.push_back(x);
    n_push++;
    #1;
  endtask

  function automatic int rand_err(int maxmag);
    int mag;
    mag = int'($urandom_range(0, maxmag));
    return ($urandom_range(0, 1) == 1) ? mag : -mag;
  endfunction

  always @(negedge refclk) begin
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_pop++;
      chk("coarse_code", int'(coarse_code), x.coarse);
      chk("fine_code", int'(fine_code), x.fine);
      chk("lock_state", int'(lock_state), int'(x.phase));
      chk("brake_state", int'(brake_state), int'(x.brake));
      chk("locked", int'(locked), x.lck);
    end
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_coarse"}, int'(coarse_code), 7);
    chk({tag, "_fine"}, int'(fine_code), 128);
    chk({tag, "_lock"}, int'(lock_state), int'(UNLOCKED));
    chk({tag, "_brake"}, int'(brake_state), int'(BRAKES_OFF));
    chk({tag, "_locked"}, int'(locked), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; count_valid = 1'b0; pd_valid = 1'b0; pd_early = 1'b0;
    fcw = 12'd100; dco_count = 12'd100;
    model_reset();
    #12;
    chk_reset_vals("por");
    #2 reset = 1'b0;
    @(posedge refclk); #1;

    // Single coarse step up, then back to reset values via enable
    cur_fcw = 100;
    cyc(1, 1, 0, 0, 10);
    for (int i = 0; i < 3; i++) cyc(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    cyc(0, 0, 0, 0, 0);

    // Coarse saturation at both ends
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 50);
    for (int i = 0; i < 18; i++) cyc(1, 1, 0, 0, -50);
    cyc(0, 0, 0, 0, 0);

    // Coarse lock, fine saturation, fine lock, phase lock
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, -2);
    for (int i = 0; i < 130; i++) cyc(1, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 1, (i % 2) == 0, 0);
      cyc(1, 0, 0, 0, 0);
    end

    // Tracking in phase lock with in-tolerance counts, some coincident
    for (int i = 0; i < 80; i++)
      cyc(1, $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 1), rand_err(16));

    // Loss of lock, braking with ignored qualifiers, recovery
    cyc(1, 1, 0, 0, -30);
    for (int i = 0; i < 20; i++)
      cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), rand_err(60));
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 0);

    // Fully random operation
    for (int i = 0; i < 400; i++) begin
      int r, e;
      if ($urandom_range(0, 49) == 0) cur_fcw = int'($urandom_range(200, 3000));
      r = int'($urandom_range(0, 9));
      if (r <= 5) e = 0;
      else if (r <= 7) e = rand_err(4);
      else if (r == 8) e = rand_err(16);
      else e = rand_err(60);
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
          $urandom_range(0, 1), e);
    end

    // Asynchronous reset in the middle of braking
    cur_fcw = 100;
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 40);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
    chk("brake_before_reset", int'(brake_state), int'(BRAKING));
    @(negedge refclk); #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    model_reset();
    #1 reset = 1'b0;
    @(posedge refclk); #1;
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 3);

    @(negedge refclk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("pop_count", n_pop, n_push);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
